// File: rtl/drum_pkg.sv
// Shared types, sizes and voice sample-memory map for the drum voice scheduler.
package drum_pkg;

    localparam int unsigned NUM_VOICES = 4;
    localparam int unsigned STEPS      = 16;
    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned SAMPLE_W   = 8;
    localparam int unsigned VOICE_W    = $clog2(NUM_VOICES);
    localparam int unsigned STEP_W     = $clog2(STEPS);
    localparam int unsigned PTR_W      = 11;
    localparam int unsigned ACC_W      = SAMPLE_W + VOICE_W;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (SAMPLE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [VOICE_W-1:0] {
        VOICE_KICK,
        VOICE_SNARE,
        VOICE_HIHAT,
        VOICE_CLAP
    } voice_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPT,
        ST_DONE
    } state_t;

    function automatic logic [ADDR_W-1:0] voice_base(input voice_e v);
        case (v)
            VOICE_KICK:  voice_base = ADDR_W'(0);
            VOICE_SNARE: voice_base = ADDR_W'(1024);
            VOICE_HIHAT: voice_base = ADDR_W'(2048);
            default:     voice_base = ADDR_W'(3242);
        endcase
    endfunction

    function automatic logic [PTR_W-1:0] voice_len(input voice_e v);
        case (v)
            VOICE_KICK:  voice_len = PTR_W'(1024);
            VOICE_SNARE: voice_len = PTR_W'(1024);
            VOICE_HIHAT: voice_len = PTR_W'(1194);
            default:     voice_len = PTR_W'(854);
        endcase
    endfunction

    // Clamp the wide mix sum to the signed sample range.
    function automatic logic [SAMPLE_W-1:0] sat_sample(input logic signed [ACC_W-1:0] a);
        if (a > SAT_MAX)
            sat_sample = SAT_MAX[SAMPLE_W-1:0];
        else if (a < SAT_MIN)
            sat_sample = SAT_MIN[SAMPLE_W-1:0];
        else
            sat_sample = a[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/drum_voice_scheduler_if.sv
// Read port of the shared sample memory: address/strobe out, data back one cycle later.
interface drum_voice_scheduler_if;
    import drum_pkg::*;

    logic                mem_re;
    logic [ADDR_W-1:0]   mem_addr;
    logic [SAMPLE_W-1:0] mem_rdata;

    modport master (output mem_re, output mem_addr, input mem_rdata);
    modport slave  (input mem_re, input mem_addr, output mem_rdata);
endinterface

// File: rtl/drum_step_seq.sv
// Pattern RAM and step counter; raises a pending trigger per voice on each tempo step.
module drum_step_seq
    import drum_pkg::*;
(
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  step_en,
    input  logic                  run,
    input  logic                  pat_we,
    input  logic [VOICE_W-1:0]    pat_voice,
    input  logic [STEP_W-1:0]     pat_step,
    input  logic                  pat_bit,
    input  logic [NUM_VOICES-1:0] pend_clr,
    output logic [NUM_VOICES-1:0] pending,
    output logic [STEP_W-1:0]     step_idx
);

    logic [STEPS-1:0]      pattern [NUM_VOICES];
    logic                  run_q;
    logic [NUM_VOICES-1:0] hit;

    // Pattern is read before this cycle's write lands, so a colliding write is seen next time.
    always_comb begin
        hit = '0;
        if (step_en && run) begin
            for (int v = 0; v < NUM_VOICES; v++)
                hit[v] = pattern[v][step_idx];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int v = 0; v < NUM_VOICES; v++)
                pattern[v] <= '0;
            pending  <= '0;
            step_idx <= '0;
            run_q    <= 1'b0;
        end else begin
            run_q <= run;
            if (pat_we)
                pattern[pat_voice][pat_step] <= pat_bit;
            pending <= (pending & ~pend_clr) | hit;
            if (run_q && !run)
                step_idx <= '0;
            else if (step_en && run)
                step_idx <= step_idx + STEP_W'(1);
        end
    end

endmodule

// File: rtl/drum_voice_scheduler.sv
// Drum machine core: step sequencer plus a per-sample sweep of all voices through one shared ROM.
module drum_voice_scheduler
    import drum_pkg::*;
(
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  sample_en,
    input  logic                  step_en,
    input  logic                  run,
    input  logic                  pat_we,
    input  logic [VOICE_W-1:0]    pat_voice,
    input  logic [STEP_W-1:0]     pat_step,
    input  logic                  pat_bit,
    drum_voice_scheduler_if.master mem,
    output logic [SAMPLE_W-1:0]   audio_out,
    output logic                  audio_valid,
    output logic [STEP_W-1:0]     step_idx,
    output logic                  overrun
);

    state_t                   state;
    logic [VOICE_W-1:0]       vc;
    logic [VOICE_W-1:0]       vc_nxt;
    logic [PTR_W-1:0]         ptr [NUM_VOICES];
    logic [NUM_VOICES-1:0]    active;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  rdata_ext;
    logic [SAMPLE_W-1:0]      sat;
    logic [NUM_VOICES-1:0]    pending;
    logic [NUM_VOICES-1:0]    pend_clr;

    drum_step_seq u_seq (
        .clk       (clk),
        .n_rst     (n_rst),
        .step_en   (step_en),
        .run       (run),
        .pat_we    (pat_we),
        .pat_voice (pat_voice),
        .pat_step  (pat_step),
        .pat_bit   (pat_bit),
        .pend_clr  (pend_clr),
        .pending   (pending),
        .step_idx  (step_idx)
    );

    // Pending triggers are consumed at sweep start; triggers arriving the same cycle survive.
    assign pend_clr  = (state == ST_IDLE && sample_en) ? pending : '0;
    assign vc_nxt    = vc + VOICE_W'(1);
    assign rdata_ext = {{(ACC_W - SAMPLE_W){mem.mem_rdata[SAMPLE_W-1]}}, mem.mem_rdata};
    assign sat       = sat_sample(acc);

    // The read strobe/address are issued on entry to READ, so each READ cycle presents them.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= ST_IDLE;
            vc           <= '0;
            acc          <= '0;
            active       <= '0;
            for (int v = 0; v < NUM_VOICES; v++)
                ptr[v] <= '0;
            mem.mem_re   <= 1'b0;
            mem.mem_addr <= '0;
            audio_out    <= {1'b1, {(SAMPLE_W - 1){1'b0}}};
            audio_valid  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            audio_valid <= 1'b0;
            overrun     <= sample_en && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (sample_en) begin
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if (pending[v]) begin
                                ptr[v]    <= '0;
                                active[v] <= 1'b1;
                            end
                        end
                        acc          <= '0;
                        vc           <= '0;
                        state        <= ST_READ;
                        mem.mem_re   <= active[0] | pending[0];
                        mem.mem_addr <= voice_base(VOICE_KICK) +
                                        (pending[0] ? ADDR_W'(0) : ADDR_W'(ptr[0]));
                    end
                end
                ST_READ: begin
                    mem.mem_re <= 1'b0;
                    state      <= ST_CAPT;
                end
                ST_CAPT: begin
                    if (active[vc]) begin
                        acc <= acc + rdata_ext;
                        if (ptr[vc] == voice_len(voice_e'(vc)) - PTR_W'(1))
                            active[vc] <= 1'b0;
                        else
                            ptr[vc] <= ptr[vc] + PTR_W'(1);
                    end
                    if (vc == VOICE_W'(NUM_VOICES - 1)) begin
                        state <= ST_DONE;
                    end else begin
                        vc           <= vc_nxt;
                        state        <= ST_READ;
                        mem.mem_re   <= active[vc_nxt];
                        mem.mem_addr <= voice_base(voice_e'(vc_nxt)) + ADDR_W'(ptr[vc_nxt]);
                    end
                end
                ST_DONE: begin
                    audio_out   <= {~sat[SAMPLE_W-1], sat[SAMPLE_W-2:0]};
                    audio_valid <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_drum_voice_scheduler.sv
// Directed bench for drum_voice_scheduler: vector table of single sweeps plus multi-cycle sequences.
module tb_drum_voice_scheduler;

    logic       clk;
    logic       n_rst;
    logic       sample_en;
    logic       step_en;
    logic       run;
    logic       pat_we;
    logic [1:0] pat_voice;
    logic [3:0] pat_step;
    logic       pat_bit;
    logic [7:0] audio_out;
    logic       audio_valid;
    logic [3:0] step_idx;
    logic       overrun;
    logic [7:0] fill;

    int n_pass;
    int n_total;

    drum_voice_scheduler_if mif ();

    drum_voice_scheduler dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .sample_en   (sample_en),
        .step_en     (step_en),
        .run         (run),
        .pat_we      (pat_we),
        .pat_voice   (pat_voice),
        .pat_step    (pat_step),
        .pat_bit     (pat_bit),
        .mem         (mif),
        .audio_out   (audio_out),
        .audio_valid (audio_valid),
        .step_idx    (step_idx),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: every address holds the same value, returned one cycle after the request.
    always @(posedge clk) mif.mem_rdata <= fill;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  mask;
        logic [7:0]  data;
        logic [7:0]  exp_audio;
        int          exp_reads;
        logic [11:0] exp_first;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        n_rst     = 1'b0;
        sample_en = 1'b0;
        step_en   = 1'b0;
        run       = 1'b0;
        pat_we    = 1'b0;
        pat_voice = 2'd0;
        pat_step  = 4'd0;
        pat_bit   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        tick();
    endtask

    task automatic write_pat(input int v, input int s, input logic b);
        pat_we    = 1'b1;
        pat_voice = 2'(v);
        pat_step  = 4'(s);
        pat_bit   = b;
        tick();
        pat_we = 1'b0;
    endtask

    task automatic pulse_step();
        step_en = 1'b1;
        tick();
        step_en = 1'b0;
    endtask

    // One sample_en strobe, then a bounded watch of reads and the audio result.
    task automatic do_sweep(output int lat, output logic [7:0] aud, output int reads,
                            output logic [11:0] first, output int nvalid);
        lat = -1; aud = 8'hxx; reads = 0; first = 12'hfff; nvalid = 0;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (mif.mem_re) begin
                if (reads == 0) first = mif.mem_addr;
                reads++;
            end
            if (audio_valid) begin
                if (lat < 0) lat = k;
                aud = audio_out;
                nvalid++;
            end
            tick();
        end
    endtask

    initial begin
        int lat, reads, nvalid, err, vcnt, ocnt, vat, oat;
        logic [7:0]  aud, last_aud;
        logic [11:0] first, last_first;

        n_pass = 0; n_total = 0; fill = 8'h00;

        vecs[0]  = '{4'b0000, 8'h05, 8'h80, 0, 12'd0};
        vecs[1]  = '{4'b0100, 8'h05, 8'h85, 1, 12'd2048};
        vecs[2]  = '{4'b1111, 8'h7F, 8'hFF, 4, 12'd0};
        vecs[3]  = '{4'b1111, 8'h80, 8'h00, 4, 12'd0};
        vecs[4]  = '{4'b0010, 8'h10, 8'h90, 1, 12'd1024};
        vecs[5]  = '{4'b1110, 8'h20, 8'hE0, 3, 12'd1024};
        vecs[6]  = '{4'b1111, 8'h20, 8'hFF, 4, 12'd0};
        vecs[7]  = '{4'b1110, 8'hE0, 8'h20, 3, 12'd1024};
        vecs[8]  = '{4'b1111, 8'hE0, 8'h00, 4, 12'd0};
        vecs[9]  = '{4'b1000, 8'h3F, 8'hBF, 1, 12'd3242};
        vecs[10] = '{4'b1100, 8'hC0, 8'h00, 2, 12'd2048};
        vecs[11] = '{4'b1100, 8'hC1, 8'h02, 2, 12'd2048};

        reset_dut();
        check("reset_audio_out", 32'(audio_out), 32'h80);
        check("reset_audio_valid", 32'(audio_valid), 32'h0);
        check("reset_mem_re", 32'(mif.mem_re), 32'h0);
        check("reset_mem_addr", 32'(mif.mem_addr), 32'h0);
        check("reset_step_idx", 32'(step_idx), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);

        // Table: trigger a voice set on step 0, then one sweep.
        for (int i = 0; i < 12; i++) begin
            reset_dut();
            for (int v = 0; v < 4; v++)
                if (vecs[i].mask[v]) write_pat(v, 0, 1'b1);
            run = 1'b1;
            pulse_step();
            check($sformatf("vec%0d_step_idx", i), 32'(step_idx), 32'h1);
            fill = vecs[i].data;
            do_sweep(lat, aud, reads, first, nvalid);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd10);
            check($sformatf("vec%0d_nvalid", i), 32'(nvalid), 32'd1);
            check($sformatf("vec%0d_audio", i), 32'(aud), 32'(vecs[i].exp_audio));
            check($sformatf("vec%0d_reads", i), 32'(reads), 32'(vecs[i].exp_reads));
            if (vecs[i].exp_reads != 0)
                check($sformatf("vec%0d_first_addr", i), 32'(first), 32'(vecs[i].exp_first));
        end

        // Hihat plays its full length, then goes silent.
        reset_dut();
        write_pat(2, 0, 1'b1);
        run = 1'b1;
        pulse_step();
        fill = 8'h05;
        err = 0; last_aud = 8'h00; last_first = 12'h000;
        for (int i = 0; i < 1194; i++) begin
            do_sweep(lat, aud, reads, first, nvalid);
            if (reads != 1 || first != 12'(2048 + i) || aud != 8'h85) err++;
            last_aud = aud;
            last_first = first;
        end
        check("hihat_sweep_errors", 32'(err), 32'd0);
        check("hihat_last_addr", 32'(last_first), 32'd3241);
        check("hihat_last_audio", 32'(last_aud), 32'h85);
        do_sweep(lat, aud, reads, first, nvalid);
        check("hihat_after_reads", 32'(reads), 32'd0);
        check("hihat_after_audio", 32'(aud), 32'h80);

        // Write and step colliding on one cell: the step sees the old (clear) bit.
        reset_dut();
        run = 1'b1;
        pat_we = 1'b1; pat_voice = 2'd0; pat_step = 4'd0; pat_bit = 1'b1;
        step_en = 1'b1;
        tick();
        pat_we = 1'b0; step_en = 1'b0;
        do_sweep(lat, aud, reads, first, nvalid);
        check("collide_reads", 32'(reads), 32'd0);
        for (int i = 0; i < 15; i++) pulse_step();
        check("collide_wrap_idx", 32'(step_idx), 32'd0);
        pulse_step();
        do_sweep(lat, aud, reads, first, nvalid);
        check("collide_later_reads", 32'(reads), 32'd1);
        check("collide_later_addr", 32'(first), 32'd0);

        // Snare retriggered at ptr = 300 restarts from its base.
        reset_dut();
        write_pat(1, 0, 1'b1);
        run = 1'b1;
        pulse_step();
        fill = 8'h05;
        err = 0;
        for (int i = 0; i < 300; i++) begin
            do_sweep(lat, aud, reads, first, nvalid);
            if (reads != 1 || first != 12'(1024 + i)) err++;
        end
        check("snare_sweep_errors", 32'(err), 32'd0);
        for (int i = 0; i < 15; i++) pulse_step();
        check("wrap_step_idx", 32'(step_idx), 32'd0);
        pulse_step();
        check("retrig_step_idx", 32'(step_idx), 32'd1);
        do_sweep(lat, aud, reads, first, nvalid);
        check("retrig_first_addr", 32'(first), 32'd1024);
        check("retrig_audio", 32'(aud), 32'h85);

        // Second sample_en four cycles into a sweep.
        vcnt = 0; ocnt = 0; vat = -1; oat = -1;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            if (audio_valid) begin vcnt++; if (vat < 0) vat = k; end
            if (overrun) begin ocnt++; if (oat < 0) oat = k; end
            if (k == 4) sample_en = 1'b1;
            if (k == 5) sample_en = 1'b0;
            tick();
        end
        check("ovr_valid_count", 32'(vcnt), 32'd1);
        check("ovr_valid_latency", 32'(vat), 32'd10);
        check("ovr_pulse_count", 32'(ocnt), 32'd1);
        check("ovr_pulse_cycle", 32'(oat), 32'd5);

        // Run drop forces step 0; stopped steps trigger nothing.
        pulse_step();
        pulse_step();
        check("run_step_idx3", 32'(step_idx), 32'd3);
        run = 1'b0;
        tick();
        check("run_drop_idx", 32'(step_idx), 32'd0);
        pulse_step();
        check("stopped_step_idx", 32'(step_idx), 32'd0);
        do_sweep(lat, aud, reads, first, nvalid);
        check("stopped_no_retrig_addr", 32'(first), 32'd1026);

        // Reset in the middle of a sweep.
        pulse_step();
        run = 1'b1;
        pulse_step();
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        repeat (3) tick();
        n_rst = 1'b0;
        #1;
        check("midrst_audio_out", 32'(audio_out), 32'h80);
        check("midrst_mem_re", 32'(mif.mem_re), 32'h0);
        check("midrst_mem_addr", 32'(mif.mem_addr), 32'h0);
        check("midrst_step_idx", 32'(step_idx), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 15; k++) begin
            if (audio_valid) vcnt++;
            tick();
        end
        check("midrst_no_valid", 32'(vcnt), 32'd0);
        do_sweep(lat, aud, reads, first, nvalid);
        check("midrst_after_reads", 32'(reads), 32'd0);
        check("midrst_after_audio", 32'(aud), 32'h80);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/drum_voice_scheduler.md
Name: drum_voice_scheduler

Overview:
- Step sequencer plus time-multiplexed sample-ROM scheduler for the drum machine.
- Holds a 16-step trigger pattern per voice and advances one step per tempo strobe.
- On each 8 kHz sample strobe, sweeps all voices through one shared synchronous sample memory, mixes the active voices, and emits one unsigned 8-bit audio sample.

Parameters:
- NUM_VOICES, 4, number of drum voices (0 kick, 1 snare, 2 hihat, 3 clap).
- STEPS, 16, pattern length in steps.
- ADDR_W, 12, shared sample-memory address width.
- SAMPLE_W, 8, sample width; memory data is two's-complement.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset; asynchronous assert, active-low.
- sample_en  in  1  8 kHz single-cycle sample strobe.
- step_en  in  1  single-cycle tempo strobe, one per step.
- run  in  1  1 = sequencer advances; 0 = stopped.
- pat_we  in  1  pattern write strobe.
- pat_voice  in  2  voice index for the pattern write.
- pat_step  in  4  step index for the pattern write.
- pat_bit  in  1  value written to the pattern cell.
- mem_re  out  1  read strobe to the shared sample memory.
- mem_addr  out  ADDR_W  read address; data returns one cycle later.
- mem_rdata  in  SAMPLE_W  signed sample, valid the cycle after mem_re.
- audio_out  out  SAMPLE_W  mixed sample, offset binary (signed + 128).
- audio_valid  out  1  one-cycle pulse when audio_out updates.
- step_idx  out  4  current sequencer step.
- overrun  out  1  one-cycle pulse when sample_en arrives while a sweep is in progress.

Behaviour:
- Reset values:
  - pattern cleared; all voices inactive; all play pointers 0; pending triggers 0.
  - step_idx = 0; FSM in IDLE.
  - audio_out = 8'h80; audio_valid, mem_re, overrun = 0; mem_addr = 0.
- Pattern:
  - On pat_we, pattern[pat_voice][pat_step] <= pat_bit.
  - If pat_we and step_en hit the same cell in the same cycle, the step uses the old value.
- Sequencer:
  - On step_en with run = 1, set pending[v] for every v where pattern[v][step_idx] = 1.
  - In the same cycle, step_idx increments, wrapping 15 -> 0.
  - step_en with run = 0 has no effect.
  - A run falling edge forces step_idx to 0; voices already playing finish their tails.
- FSM states: IDLE, READ, CAPT, DONE; voice counter vc.
  - IDLE, on sample_en:
    - Apply pending: for each pending voice, ptr <= 0, active <= 1, pending <= 0. A retrigger restarts a playing voice.
    - Clear the accumulator; vc <= 0; go to READ.
  - READ:
    - mem_re = active[vc]; mem_addr = VOICE_BASE[vc] + ptr[vc]; go to CAPT.
  - CAPT:
    - If active[vc], sign-extend mem_rdata into the accumulator and advance that voice's pointer.
    - If ptr[vc] = VOICE_LEN[vc] - 1, clear active[vc]; otherwise ptr[vc]++.
    - If vc = NUM_VOICES-1, go to DONE; else vc++ and go to READ.
  - DONE:
    - Saturate the accumulator to [-128, 127]; audio_out <= sat + 128 (MSB flip); audio_valid = 1.
    - Go to IDLE.
- Timing:
  - Inactive voices still take their READ/CAPT slots, with mem_re = 0 and a contribution of 0.
  - Latency is fixed: audio_valid fires 2*NUM_VOICES+2 = 10 cycles after the sample_en cycle.
- Accumulator is SAMPLE_W + clog2(NUM_VOICES) = 10 bits, signed.
- sample_en outside IDLE is ignored and pulses overrun.
- step_en mid-sweep only sets pending, so the current sweep is not disturbed.
- Reset asserted mid-sweep: all state returns to reset values immediately; no audio_valid.

Decomposition:
- Package drum_pkg holds:
  - VOICE_BASE[0:3] = 0, 1024, 2048, 3242.
  - VOICE_LEN[0:3] = 1024, 1024, 1194, 854.
  - voice_e enum; the state_t enum.
- One sub-module, drum_step_seq: pattern RAM, step_idx, run handling, pending-trigger generation.
- Scheduler FSM, pointers and mixer stay in the top module.

Test Plan:
- Reset, then sample_en with an empty pattern -> audio_valid pulses 10 cycles later with audio_out = 8'h80; mem_re never asserted.
- Write pattern[2][0] = 1, run = 1, step_en, sample_en, memory returns 8'h05 -> mem_addr = 2048 in the first voice-2 READ; audio_out = 8'h85; step_idx = 1.
- Play hihat to completion -> exactly 1194 reads at addresses 2048..3241, then active[2] clears and audio_out returns to 8'h80.
- All 4 voices triggered with memory returning 8'h7F -> sum 508, saturates, audio_out = 8'hFF. Repeat with 8'h80 -> audio_out = 8'h00.
- step_en retriggering voice 1 mid-playback at ptr = 300 -> next sweep reads address 1024. A second sample_en 4 cycles after the first -> overrun pulse and no extra audio_valid.
- 16 step_en pulses -> step_idx wraps 15 -> 0. Drop run -> step_idx = 0. Assert n_rst low mid-sweep -> outputs at reset values and no audio_valid.
